// File: rtl/life_pkg.sv
// Shared definitions for the life-engine timebase and step pacing.
//   ST_IDLE / ST_WAIT_ACK : step-request FSM encoding
//   PERIOD_W_DEF          : default width of the generation period in ms
//   CLK_PER_MS            : clk cycles per millisecond (timer and bench agree on it)
package life_pkg;

   localparam logic ST_IDLE     = 1'b0;
   localparam logic ST_WAIT_ACK = 1'b1;

   localparam int unsigned PERIOD_W_DEF = 10;
   localparam int unsigned CLK_PER_MS   = 50_000;

endpackage

// File: rtl/toggle_sync_tick.sv
// Synchronises a slow toggling level into clk and emits a one-cycle tick per
// toggle (rising or falling). A short prime window after reset hides the
// false edge seen when the input is already high at reset release.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   din  : toggling level, asynchronous to clk
//   tick : registered one-cycle pulse, SYNC_STAGES+1 edges after din changes
module toggle_sync_tick #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic tick
);

   localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);
   localparam logic [PRIME_W-1:0] PRIME_INIT = PRIME_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [PRIME_W-1:0]     prime_q;

   // Synchroniser chain, edge history and primed tick register
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         prime_q <= PRIME_INIT;
         tick    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
         if (prime_q != '0) begin
            prime_q <= prime_q - PRIME_W'(1);
            tick    <= 1'b0;
         end else begin
            tick <= sync_q[SYNC_STAGES-1] ^ hist_q;
         end
      end
   end

endmodule

// File: rtl/gen_step_pacer.sv
// Paces life-engine generations from the millisecond timebase: counts ticks
// to a programmable period and raises a held step request per period, with
// pause, single-step and sticky overrun reporting.
//   clk, rst     : system clock, synchronous active-high reset
//   clk_1ms      : toggling timebase (async level)
//   run          : 1 = free-running, 0 = paused
//   single_step  : one-cycle pulse, one generation while paused and idle
//   period_ms    : ticks per generation (0 treated as 1)
//   step_ack     : engine accepts the pending step
//   clr_overrun  : one-cycle pulse clearing overrun
//   step_req     : step request, held until acked
//   tick_1ms     : one-cycle pulse per clk_1ms toggle
//   overrun      : sticky, a period expired while a request was outstanding
//   busy         : request outstanding
module gen_step_pacer
   import life_pkg::*;
#(
   parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_1ms,
   input  logic                run,
   input  logic                single_step,
   input  logic [PERIOD_W-1:0] period_ms,
   input  logic                step_ack,
   input  logic                clr_overrun,
   output logic                step_req,
   output logic                tick_1ms,
   output logic                overrun,
   output logic                busy
);

   logic                tick;
   logic [PERIOD_W-1:0] ms_cnt_q;
   logic [PERIOD_W-1:0] last_c;
   logic                expiry_c;
   logic                state_q;
   logic                state_n;
   logic                overrun_q;

   toggle_sync_tick #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .din  (clk_1ms),
      .tick (tick)
   );

   assign tick_1ms = tick;

   // Last count of the period; >= compare so a lowered period expires next tick
   always_comb begin
      last_c = (period_ms == '0) ? '0 : period_ms - PERIOD_W'(1);
   end

   assign expiry_c = tick & run & (ms_cnt_q >= last_c);

   // Millisecond counter, parked at zero while paused
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         ms_cnt_q <= '0;
      end else if (tick) begin
         ms_cnt_q <= expiry_c ? '0 : ms_cnt_q + PERIOD_W'(1);
      end
   end

   // Request FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_n;
   end

   // Request FSM next state; the ack edge always lands in IDLE
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE: begin
            if ((run && expiry_c) || (!run && single_step)) state_n = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (step_ack) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Sticky overrun; a set in the same cycle beats the clear
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if ((state_q == ST_WAIT_ACK) && expiry_c) begin
         overrun_q <= 1'b1;
      end else if (clr_overrun) begin
         overrun_q <= 1'b0;
      end
   end

   assign step_req = (state_q == ST_WAIT_ACK);
   assign busy     = (state_q == ST_WAIT_ACK);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_gen_step_pacer.sv
// Self-checking bench for gen_step_pacer: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model that
// works from the sampled clk_1ms history and the pacing rules.
module tb_gen_step_pacer;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_1ms;
   logic       run;
   logic       single_step;
   logic [9:0] period_ms;
   logic       step_ack;
   logic       clr_overrun;
   logic       step_req;
   logic       tick_1ms;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic        smp [4];     // smp[k] = clk_1ms sampled k edges ago
   int unsigned since_rst;
   logic        m_tick;
   int unsigned m_cnt;
   logic        m_req;
   logic        m_ovr;

   gen_step_pacer dut (
      .clk         (clk),
      .rst         (rst),
      .clk_1ms     (clk_1ms),
      .run         (run),
      .single_step (single_step),
      .period_ms   (period_ms),
      .step_ack    (step_ack),
      .clr_overrun (clr_overrun),
      .step_req    (step_req),
      .tick_1ms    (tick_1ms),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clk edge: apply inputs, advance the model, compare all outputs.
   task automatic step();
      logic        i_rst, i_din, i_run, i_ss, i_ack, i_clr;
      int unsigned eff;
      logic        expired;
      logic        set_ovr;
      i_rst = rst; i_din = clk_1ms; i_run = run; i_ss = single_step;
      i_ack = step_ack; i_clr = clr_overrun;
      eff   = (period_ms == 10'd0) ? 1 : int'(period_ms);
      @(posedge clk);
      #1;
      if (i_rst) begin
         for (int k = 0; k < 4; k++) smp[k] = 1'b0;
         since_rst = 0;
         m_tick = 1'b0; m_cnt = 0; m_req = 1'b0; m_ovr = 1'b0;
      end else begin
         expired = m_tick && i_run && (m_cnt + 1 >= eff);
         if (!i_run)      m_cnt = 0;
         else if (m_tick) m_cnt = expired ? 0 : m_cnt + 1;
         set_ovr = 1'b0;
         if (m_req) begin
            set_ovr = expired;
            if (i_ack) m_req = 1'b0;
         end else if ((i_run && expired) || (!i_run && i_ss)) begin
            m_req = 1'b1;
         end
         if (set_ovr)    m_ovr = 1'b1;
         else if (i_clr) m_ovr = 1'b0;
         // tick reflects a change seen two edges deep in the sampled history
         since_rst++;
         smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = i_din;
         m_tick = (since_rst > 3) && (smp[2] != smp[3]);
      end
      single_step = 1'b0;
      clr_overrun = 1'b0;
      check("tick_1ms", 32'(tick_1ms), 32'(m_tick));
      check("step_req", 32'(step_req), 32'(m_req));
      check("busy",     32'(busy),     32'(m_req));
      check("overrun",  32'(overrun),  32'(m_ovr));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // One clk_1ms toggle followed by enough cycles for its tick to be consumed,
   // with the engine acking one cycle after each request when follow_ack is set.
   task automatic ms_tick(input logic follow_ack);
      clk_1ms = ~clk_1ms;
      for (int i = 0; i < 6; i++) begin
         if (follow_ack) step_ack = step_req;
         step();
      end
      step_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clk_1ms = 1'b1; run = 1'b0; single_step = 1'b0;
      period_ms = 10'd4; step_ack = 1'b0; clr_overrun = 1'b0;
      for (int k = 0; k < 4; k++) smp[k] = 1'b0;
      since_rst = 0; m_tick = 1'b0; m_cnt = 0; m_req = 1'b0; m_ovr = 1'b0;

      // reset with clk_1ms high: no spurious tick after release
      steps(3);
      check("reset_req", 32'(step_req), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("prime_tick", 32'(tick_1ms), 32'd0);
      end

      // tick latency for both toggle directions
      for (int d = 0; d < 2; d++) begin
         clk_1ms = ~clk_1ms;
         steps(2);
         check("lat_early", 32'(tick_1ms), 32'd0);
         step();
         check("lat_tick", 32'(tick_1ms), 32'd1);
         step();
         check("lat_one_cycle", 32'(tick_1ms), 32'd0);
         steps(2);
      end

      // free run, period 4, prompt acks
      run = 1'b1; period_ms = 10'd4;
      for (int i = 0; i < 20; i++) ms_tick(1'b1);
      check("free_no_overrun", 32'(overrun), 32'd0);

      // overrun with no ack, then clear without / with a coinciding tick
      period_ms = 10'd1;
      ms_tick(1'b0);
      check("ovr_req", 32'(step_req), 32'd1);
      ms_tick(1'b0);
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_busy", 32'(busy), 32'd1);
      clr_overrun = 1'b1;
      step();
      check("ovr_clr", 32'(overrun), 32'd0);
      clk_1ms = ~clk_1ms;
      steps(3);
      clr_overrun = 1'b1;
      step();
      check("ovr_set_wins", 32'(overrun), 32'd1);
      step_ack = 1'b1; step(); step_ack = 1'b0;
      steps(2);

      // single step while paused; second pulse while busy is ignored
      run = 1'b0;
      steps(2);
      single_step = 1'b1; step();
      check("ss_req", 32'(step_req), 32'd1);
      single_step = 1'b1; step();
      step_ack = 1'b1; step(); step_ack = 1'b0;
      steps(3);
      check("ss_one_only", 32'(step_req), 32'd0);
      run = 1'b1; period_ms = 10'd10;
      single_step = 1'b1; step();
      check("ss_running_ignored", 32'(step_req), 32'd0);

      // period lowered below the running count expires on the next tick
      for (int i = 0; i < 6; i++) ms_tick(1'b0);
      check("lower_before", 32'(step_req), 32'd0);
      period_ms = 10'd2;
      ms_tick(1'b0);
      check("lower_after", 32'(step_req), 32'd1);
      step_ack = 1'b1; step(); step_ack = 1'b0;

      // period 0 behaves as 1
      period_ms = 10'd0;
      for (int i = 0; i < 5; i++) ms_tick(1'b1);

      // reset withdraws a pending request
      run = 1'b0;
      single_step = 1'b1; step();
      rst = 1'b1; step();
      check("rst_withdraw", 32'(step_req), 32'd0);
      rst = 1'b0;
      steps(4);

      // randomized traffic
      run = 1'b1; period_ms = 10'd3;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0)   clk_1ms = ~clk_1ms;
         if ($urandom_range(0, 59) == 0)  run = ~run;
         if ($urandom_range(0, 99) == 0)  period_ms = 10'($urandom_range(0, 5));
         step_ack    = ($urandom_range(0, 2) == 0);
         single_step = ($urandom_range(0, 19) == 0);
         clr_overrun = ($urandom_range(0, 29) == 0);
         rst         = ($urandom_range(0, 799) == 0);
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
